// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width/sign codes, FSM states
// and the funct3 legality check used by the alignment block.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_FUNCT3_B  = 3'b000;
    localparam logic [2:0] LSU_FUNCT3_H  = 3'b001;
    localparam logic [2:0] LSU_FUNCT3_W  = 3'b010;
    localparam logic [2:0] LSU_FUNCT3_BU = 3'b100;
    localparam logic [2:0] LSU_FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    // Unsigned variants exist only for loads; every other code is illegal.
    function automatic logic lsu_funct3_illegal(input logic is_store, input logic [2:0] funct3);
        logic illegal;
        case (funct3)
            LSU_FUNCT3_B, LSU_FUNCT3_H, LSU_FUNCT3_W: illegal = 1'b0;
            LSU_FUNCT3_BU, LSU_FUNCT3_HU:             illegal = is_store;
            default:                                  illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store data replication, load extraction
// with sign/zero extension, and the misaligned/illegal access checks.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_val_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] lane_s;

    assign lane_s = rdata_i >> {addr_lo_i, 3'b000};

    // Lane mask and replicated write data; the low two funct3 bits give the size.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Load result extension from the selected lane.
    always_comb begin
        load_val_o = 32'h0000_0000;
        case (funct3_i)
            LSU_FUNCT3_B:  load_val_o = {{24{lane_s[7]}}, lane_s[7:0]};
            LSU_FUNCT3_H:  load_val_o = {{16{lane_s[15]}}, lane_s[15:0]};
            LSU_FUNCT3_W:  load_val_o = rdata_i;
            LSU_FUNCT3_BU: load_val_o = {24'h00_0000, lane_s[7:0]};
            LSU_FUNCT3_HU: load_val_o = {16'h0000, lane_s[15:0]};
            default:       load_val_o = 32'h0000_0000;
        endcase
    end

    // Illegal codes take precedence, so misaligned is only raised on legal widths.
    always_comb begin
        illegal_o    = lsu_funct3_illegal(is_store_i, funct3_i);
        misaligned_o = 1'b0;
        if (!illegal_o) begin
            misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                           ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
        end else begin
            misaligned_o = 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one load/store at a time from execute, runs a req/ack
// bus cycle with timeout, and reports completion with a one-cycle done pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned_q, misaligned_d;
    logic        fault_q, fault_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        sel_live_s;
    logic        al_is_store_s;
    logic [2:0]  al_funct3_s;
    logic [1:0]  al_addr_lo_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_s;
    logic [31:0] al_load_s;
    logic        al_misaligned_s;
    logic        al_illegal_s;

    // In IDLE the checks look at the incoming request; afterwards at the latched one.
    assign sel_live_s    = (state_q == LSU_IDLE);
    assign al_is_store_s = sel_live_s ? is_store      : is_store_q;
    assign al_funct3_s   = sel_live_s ? funct3        : funct3_q;
    assign al_addr_lo_s  = sel_live_s ? address[1:0]  : addr_lo_q;

    lsu_align u_align (
        .is_store_i   (al_is_store_s),
        .funct3_i     (al_funct3_s),
        .addr_lo_i    (al_addr_lo_s),
        .store_data_i (store_data),
        .rdata_i      (mem_rdata),
        .be_o         (al_be_s),
        .wdata_o      (al_wdata_s),
        .load_val_o   (al_load_s),
        .misaligned_o (al_misaligned_s),
        .illegal_o    (al_illegal_s)
    );

    // Next-state and datapath update for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = address[1:0];
                    if (al_illegal_s) begin
                        state_d     = LSU_RESP;
                        fault_d     = 1'b1;
                        load_data_d = 32'h0000_0000;
                    end else if (al_misaligned_s) begin
                        state_d      = LSU_RESP;
                        misaligned_d = 1'b1;
                        load_data_d  = 32'h0000_0000;
                    end else begin
                        state_d     = LSU_ACCESS;
                        cnt_d       = '0;
                        mem_we_d    = is_store;
                        mem_addr_d  = {address[31:2], 2'b00};
                        mem_wdata_d = al_wdata_s;
                        mem_be_d    = al_be_s;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                if (mem_ack) begin
                    state_d     = LSU_RESP;
                    load_data_d = is_store_q ? 32'h0000_0000 : al_load_s;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = LSU_RESP;
                    fault_d     = 1'b1;
                    load_data_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_RESP: begin
                state_d      = LSU_IDLE;
                misaligned_d = 1'b0;
                fault_d      = 1'b0;
            end
            default: begin
                state_d      = LSU_IDLE;
                misaligned_d = 1'b0;
                fault_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            load_data_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    assign busy       = (state_q != LSU_IDLE);
    assign done       = (state_q == LSU_RESP);
    assign mem_req    = (state_q == LSU_ACCESS);
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign fault      = fault_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-access reference model sets per-cycle
// expectations that one compare process checks, plus literal checks on captured results.
module tb_load_store_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] address, store_data;
    logic        busy, done, misaligned, fault, mem_req, mem_we, mem_ack;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en = 1'b0;
    logic        exp_busy, exp_done, exp_req, exp_mis, exp_flt, exp_we;
    logic [31:0] exp_load, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    logic [31:0] cap_load, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_mis, cap_flt, cap_we;
    int          req_total = 0;
    int          done_total = 0;

    load_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .address(address), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data),
        .misaligned(misaligned), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference model: access size, lane arithmetic and extension from the ISA rules.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld,
                         output logic mis, output logic flt);
        int size, off;
        longint mask, v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        flt = (size == 0) || (st && f3 > 3'd2);
        off = int'(a % 4);
        mis = !flt && ((off % (size == 0 ? 1 : size)) != 0);
        be = 4'b0000; wd = 32'h0; ld = 32'h0;
        if (!flt) begin
            mask = (64'd1 << (8 * size)) - 1;
            be   = 4'(((1 << size) - 1) << off);
            v = 0;
            for (int i = 0; i < 4 / size; i++) v = v | ((longint'(sd) & mask) << (8 * size * i));
            wd = v[31:0];
            v = (longint'(rd) >> (8 * off)) & mask;
            if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            ld = v[31:0];
        end
    endtask

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_flt = 1'b0;
    endtask

    // One transaction; ack_at = ACCESS cycle (1-based) carrying mem_ack, 0 = never.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int ack_at, input logic hold_start);
        logic [3:0]  m_be;
        logic [31:0] m_wd, m_ld;
        logic        m_mis, m_flt;
        model(st, f3, a, sd, rd, m_be, m_wd, m_ld, m_mis, m_flt);
        @(negedge clock);
        start = 1'b1; is_store = st; funct3 = f3; address = a; store_data = sd;
        exp_busy = 1'b1;
        if (m_flt || m_mis) begin
            exp_done = 1'b1; exp_req = 1'b0; exp_mis = m_mis; exp_flt = m_flt; exp_load = 32'h0;
        end else begin
            exp_done = 1'b0; exp_req = 1'b1;
            exp_addr = {a[31:2], 2'b00}; exp_be = m_be; exp_wdata = m_wd; exp_we = st;
            for (int cyc = 1; cyc <= TB_TIMEOUT; cyc++) begin
                @(negedge clock);
                start = hold_start; mem_rdata = rd; mem_ack = (cyc == ack_at);
                if (cyc == ack_at) begin
                    exp_req = 1'b0; exp_done = 1'b1; exp_load = st ? 32'h0 : m_ld;
                    break;
                end else if (cyc == TB_TIMEOUT) begin
                    exp_req = 1'b0; exp_done = 1'b1; exp_flt = 1'b1; exp_load = 32'h0;
                end
            end
        end
        @(negedge clock);
        mem_ack = 1'b0; start = hold_start;
        set_idle_exp();
        @(negedge clock);
        start = 1'b0;
    endtask

    // Per-cycle comparison against the model expectations, plus capture for literal checks.
    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("misaligned", 32'(misaligned), 32'(exp_mis));
            chk("fault", 32'(fault), 32'(exp_flt));
            chk("load_data", load_data, exp_load);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
            end
        end
        if (mem_req) begin
            req_total++;
            cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
        end
        if (done) begin
            done_total++;
            cap_load = load_data; cap_mis = misaligned; cap_flt = fault;
        end
    end

    initial begin
        int r0, d0;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        address = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        set_idle_exp(); exp_load = 32'h0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_we = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0; chk_en = 1'b1;
        @(negedge clock);
        chk("reset mem_be", 32'(mem_be), 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);

        d0 = done_total;
        do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        chk("SW be", 32'(cap_be), 32'hF);
        chk("SW wdata", cap_wdata, 32'hDEADBEEF);
        chk("SW we", 32'(cap_we), 32'h1);
        chk("SW done count", 32'(done_total - d0), 32'd1);

        do_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 2, 1'b0);
        chk("SB addr", cap_addr, 32'h100);
        chk("SB be", 32'(cap_be), 32'h8);
        chk("SB wdata", cap_wdata, 32'hA5A5A5A5);

        do_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12807F34, 1, 1'b0);
        chk("LB data", cap_load, 32'hFFFFFF80);
        do_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12807F34, 1, 1'b0);
        chk("LBU data", cap_load, 32'h00000080);
        do_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h12807F34, 2, 1'b0);
        chk("LH data", cap_load, 32'h00001280);
        do_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'hF0F01234, 1, 1'b0);
        chk("LH neg data", cap_load, 32'hFFFFF0F0);
        do_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'hF0F01234, 1, 1'b0);
        chk("LHU data", cap_load, 32'h0000F0F0);
        do_txn(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1, 1'b0);
        chk("SH be", 32'(cap_be), 32'hC);
        chk("SH wdata", cap_wdata, 32'hBEEFBEEF);

        r0 = req_total;
        do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        chk("LW misaligned flag", 32'(cap_mis), 32'h1);
        chk("LW misaligned no req", 32'(req_total - r0), 32'd0);
        do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        chk("load f3=011 fault", 32'(cap_flt), 32'h1);
        do_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        chk("store f3=100 fault", 32'(cap_flt), 32'h1);
        do_txn(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        chk("load f3=110 fault", 32'(cap_flt), 32'h1);
        chk("illegal no req", 32'(req_total - r0), 32'd0);

        r0 = req_total; d0 = done_total;
        do_txn(1'b0, 3'b010, 32'h108, 32'h0, 32'h55555555, 0, 1'b0);
        chk("timeout req cycles", 32'(req_total - r0), 32'd4);
        chk("timeout fault", 32'(cap_flt), 32'h1);
        @(negedge clock);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("late ack ignored", 32'(done_total - d0), 32'd1);

        @(negedge clock);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; address = 32'h200; store_data = 32'h11223344;
        exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 32'h200; exp_be = 4'hF; exp_wdata = 32'h11223344; exp_we = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        set_idle_exp(); exp_load = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        r0 = req_total; d0 = done_total;
        do_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 1'b1);
        @(negedge clock);
        chk("held start req cycles", 32'(req_total - r0), 32'd3);
        chk("held start done count", 32'(done_total - d0), 32'd1);
        chk("LW data", cap_load, 32'hCAFEF00D);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
